demux_1to4_64bit_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer. It accepts 64-bit words on a single valid/ready input, each tagged with a 2-bit destination select, and steers each word to exactly one of four valid/ready output channels. It is the distribution-side counterpart of the 4:1 data multiplexer in the datapath library. It sits where one producer fans out to four consumers. Per-channel saturating transfer counters support bring-up and performance checks.

---
 rtl/demux_1to4_64bit_stream.sv | 81 ++++++++
 tb/tb_demux_1to4_64bit_stream.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_64bit_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a single holding stage.
// Each channel also has a saturating counter of completed transfers.
module demux_1to4_64bit_stream #(
  parameter int WIDTH     = 64,
  parameter int SEL_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [WIDTH-1:0]     data0,
  output logic [WIDTH-1:0]     data1,
  output logic [WIDTH-1:0]     data2,
  output logic [WIDTH-1:0]     data3,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic [CNT_WIDTH-1:0] cnt2,
  output logic [CNT_WIDTH-1:0] cnt3
);

  logic                 full;
  logic [SEL_WIDTH-1:0] dst;
  logic [WIDTH-1:0]     hold_data;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic                 out_fire;
  logic                 in_fire;

  // Only the addressed consumer's ready matters; others are ignored (head-of-line blocking).
  assign out_fire = full && out_ready[dst];
  assign in_ready = !full || out_fire;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      dst       <= '0;
      hold_data <= '0;
    end else if (in_fire) begin
      full      <= 1'b1;
      dst       <= in_sel;
      hold_data <= in_data;
    end else if (out_fire) begin
      full      <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_valid
      assign out_valid[gi] = full && (dst == SEL_WIDTH'(gi));
    end
  endgenerate

  assign data0 = out_valid[0] ? hold_data : '0;
  assign data1 = out_valid[1] ? hold_data : '0;
  assign data2 = out_valid[2] ? hold_data : '0;
  assign data3 = out_valid[3] ? hold_data : '0;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (out_fire && (cnt_q[dst] != '1)) begin
      cnt_q[dst] <= cnt_q[dst] + CNT_WIDTH'(1);
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4_64bit_stream.sv
// Directed bench for demux_1to4_64bit_stream: a default instance plus a 4-bit-counter
// instance sharing the same stimulus for the saturation case.
module tb_demux_1to4_64bit_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;
  logic        cnt_clr;

  logic        in_ready;
  logic [3:0]  out_valid;
  logic [63:0] data0, data1, data2, data3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;

  logic        s_in_ready;
  logic [3:0]  s_out_valid;
  logic [63:0] s_data0, s_data1, s_data2, s_data3;
  logic [3:0]  s_cnt0, s_cnt1, s_cnt2, s_cnt3;

  logic [63:0] dq [4];
  logic [15:0] cq [4];

  int n_cmp;
  int n_err;

  localparam logic [63:0] PAT_A5 = 64'hA5A5_A5A5_A5A5_A5A5;

  demux_1to4_64bit_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  demux_1to4_64bit_stream #(.CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(s_out_valid), .out_ready(out_ready),
    .data0(s_data0), .data1(s_data1), .data2(s_data2), .data3(s_data3),
    .cnt_clr(cnt_clr), .cnt0(s_cnt0), .cnt1(s_cnt1), .cnt2(s_cnt2), .cnt3(s_cnt3)
  );

  assign dq[0] = data0;
  assign dq[1] = data1;
  assign dq[2] = data2;
  assign dq[3] = data3;
  assign cq[0] = cnt0;
  assign cq[1] = cnt1;
  assign cq[2] = cnt2;
  assign cq[3] = cnt3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 64'h11; out_ready = 4'b1111;
    tick();
    in_sel = 2'd3; in_data = 64'h22; out_ready = 4'b0111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_pre_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b1000) begin n_err++; $display("FAIL rst_pre_valid got %b want 1000", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_pre_in_ready_stall got %b want 0", in_ready); end
    n_cmp++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL rst_pre_cnt1 got %0d want 1", cnt1); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid got %b want 0000", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if ((data0 | data1 | data2 | data3) !== 64'h0) begin n_err++; $display("FAIL rst_data got %h/%h/%h/%h want 0", data0, data1, data2, data3); end
    n_cmp++; if ({cnt0, cnt1, cnt2, cnt3} !== 64'h0) begin n_err++; $display("FAIL rst_cnt got %0d/%0d/%0d/%0d want 0", cnt0, cnt1, cnt2, cnt3); end
    n_cmp++; if ({s_cnt0, s_cnt1, s_cnt2, s_cnt3} !== 16'h0) begin n_err++; $display("FAIL rst_cnt_sat got %h want 0", {s_cnt0, s_cnt1, s_cnt2, s_cnt3}); end
    out_ready = 4'b1111;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL rst_dropped_valid got %b want 0000", out_valid); end
    n_cmp++; if (cnt3 !== 16'd0) begin n_err++; $display("FAIL rst_dropped_cnt3 got %0d want 0", cnt3); end
  endtask

  task automatic test_steering();
    in_valid = 1'b1; in_sel = 2'd2; in_data = PAT_A5; out_ready = 4'b1111;
    tick();
    in_valid = 1'b0; in_data = 64'h0;
    #1;
    n_cmp++; if (out_valid !== 4'b0100) begin n_err++; $display("FAIL steer_valid got %b want 0100", out_valid); end
    n_cmp++; if (data2 !== PAT_A5) begin n_err++; $display("FAIL steer_data2 got %h want %h", data2, PAT_A5); end
    n_cmp++; if ((data0 | data1 | data3) !== 64'h0) begin n_err++; $display("FAIL steer_others got %h/%h/%h want 0", data0, data1, data3); end
    tick();
    n_cmp++; if (cnt2 !== 16'd1) begin n_err++; $display("FAIL steer_cnt2 got %0d want 1", cnt2); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL steer_drained got %b want 0000", out_valid); end
  endtask

  task automatic test_back_pressure();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 64'h1234; out_ready = 4'b1101;
    tick();
    in_sel = 2'd2; in_data = 64'hDEAD;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      n_cmp++; if (data1 !== 64'h1234) begin n_err++; $display("FAIL bp_data1[%0d] got %h want 1234", i, data1); end
      n_cmp++; if (out_valid !== 4'b0010) begin n_err++; $display("FAIL bp_valid[%0d] got %b want 0010", i, out_valid); end
      tick();
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL bp_after_valid got %b want 0000", out_valid); end
    tick();
    n_cmp++; if (cnt1 !== 16'd1) begin n_err++; $display("FAIL bp_cnt1 got %0d want 1", cnt1); end
    n_cmp++; if (cnt2 !== 16'd1) begin n_err++; $display("FAIL bp_cnt2 got %0d want 1", cnt2); end
  endtask

  task automatic test_streaming();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++; if ({cnt0, cnt1, cnt2, cnt3} !== 64'h0) begin n_err++; $display("FAIL stream_clr got %0d/%0d/%0d/%0d want 0", cnt0, cnt1, cnt2, cnt3); end
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 2'(i % 4); in_data = 64'h100 + 64'(i);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
      if (i > 0) begin
        n_cmp++; if (out_valid !== (4'b0001 << ((i - 1) % 4))) begin n_err++; $display("FAIL stream_valid[%0d] got %b want %b", i, out_valid, 4'b0001 << ((i - 1) % 4)); end
        n_cmp++; if (dq[(i - 1) % 4] !== 64'h100 + 64'(i - 1)) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, dq[(i - 1) % 4], 64'h100 + 64'(i - 1)); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 4'b1000 || data3 !== 64'h107) begin n_err++; $display("FAIL stream_last got %b/%h want 1000/107", out_valid, data3); end
    tick();
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (cq[c] !== 16'd2) begin n_err++; $display("FAIL stream_cnt%0d got %0d want 2", c, cq[c]); end
    end
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1; in_sel = 2'd3; in_data = 64'h77; out_ready = 4'b0000;
    tick();
    in_sel = 2'd0; in_data = 64'hFF; out_ready = 4'b1000;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    n_cmp++; if (out_valid !== 4'b0001) begin n_err++; $display("FAIL simul_valid got %b want 0001", out_valid); end
    n_cmp++; if (data0 !== 64'hFF) begin n_err++; $display("FAIL simul_data0 got %h want ff", data0); end
    n_cmp++; if (data3 !== 64'h0) begin n_err++; $display("FAIL simul_data3 got %h want 0", data3); end
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_sel = 2'd0; in_data = 64'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (s_cnt0 !== 4'd15) begin n_err++; $display("FAIL sat_cnt0 got %0d want 15", s_cnt0); end
    n_cmp++; if (cnt0 !== 16'd17) begin n_err++; $display("FAIL wide_cnt0 got %0d want 17", cnt0); end
    in_valid = 1'b1; in_sel = 2'd0; in_data = 64'h5A;
    tick();
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++; if (s_cnt0 !== 4'd0) begin n_err++; $display("FAIL sat_clr_cnt0 got %0d want 0", s_cnt0); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_err++; $display("FAIL wide_clr_cnt0 got %0d want 0", cnt0); end
    n_cmp++; if (out_valid !== 4'b0000) begin n_err++; $display("FAIL sat_drained got %b want 0000", out_valid); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    test_reset();
    test_steering();
    test_back_pressure();
    test_streaming();
    test_simultaneous();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
